// File: rtl/capa_pkg.sv
// Shared constants and helpers for the transaction-layer output word counters.
package capa_pkg;
  localparam int N_FIFOS = 4;
  localparam int CNT_W   = 5;
  localparam int IDX_W   = 3;
  localparam int INC_W   = 3;
  localparam logic [IDX_W-1:0] IDX_SUM = 3'd4;

  function automatic logic [INC_W-1:0] popcount(input logic [N_FIFOS-1:0] m);
    logic [INC_W-1:0] pc;
    pc = '0;
    for (int i = 0; i < N_FIFOS; i++) pc = pc + {{(INC_W-1){1'b0}}, m[i]};
    return pc;
  endfunction
endpackage

// File: rtl/contador_inc.sv
// Single CNT_W-bit counter advancing by 0..4 per cycle.
// COUNTER_SATURATE_EN clamps at the maximum; otherwise the count wraps.
module contador_inc
  import capa_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt
);

`ifdef COUNTER_SATURATE_EN
  logic [CNT_W:0] sum;
  assign sum = {1'b0, cnt} + {{(CNT_W-2){1'b0}}, inc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cnt <= '0;
    else if (sum[CNT_W]) cnt <= '1;
    else              cnt <= sum[CNT_W-1:0];
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt + {{(CNT_W-INC_W){1'b0}}, inc};
  end
`endif

endmodule

// File: rtl/contador_palabras.sv
// Pop counters for the four output FIFOs plus an aggregate, read back while idle.
// Optional COUNTER_SATURATE_EN makes all counters saturate instead of wrapping.
module contador_palabras
  import capa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [N_FIFOS-1:0] pop,
  input  logic [N_FIFOS-1:0] fifo_empty,
  input  logic               idle,
  input  logic               req,
  input  logic [IDX_W-1:0]   idx,
  output logic [CNT_W-1:0]   salida_contador,
  output logic               valid_contador
);

  logic [N_FIFOS-1:0]            vpop;
  logic [N_FIFOS:0][INC_W-1:0]   inc;
  logic [N_FIFOS:0][CNT_W-1:0]   cnt;
  logic                          rd_ok;
  logic [CNT_W-1:0]              rd_sel;

  assign vpop = pop & ~fifo_empty;

  // Lanes 0..N_FIFOS-1 count their own FIFO; the last lane takes the popcount.
  genvar g;
  generate
    for (g = 0; g < N_FIFOS; g++) begin : g_lane
      assign inc[g] = {{(INC_W-1){1'b0}}, vpop[g]};
    end
  endgenerate
  assign inc[N_FIFOS] = popcount(vpop);

  contador_inc u_cnt [N_FIFOS:0] (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .cnt   (cnt)
  );

  assign rd_ok = req & idle & (idx <= IDX_SUM);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= N_FIFOS; i++)
      if (idx == i[IDX_W-1:0]) rd_sel = cnt[i];
  end

  // Reads capture the pre-increment count; unserviced cycles return zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      salida_contador <= '0;
      valid_contador  <= 1'b0;
    end else begin
      salida_contador <= rd_ok ? rd_sel : '0;
      valid_contador  <= rd_ok;
    end
  end

endmodule

// File: tb/tb_contador_palabras.sv
// Scoreboard bench for contador_palabras: reference counters predict every read.
module tb_contador_palabras;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pop, fifo_empty;
  logic       idle, req;
  logic [2:0] idx;
  logic [4:0] salida_contador;
  logic       valid_contador;

  int nvec = 0;
  int nerr = 0;
  int m [5];
  logic [5:0] sbq [$];

  contador_palabras dut (
    .clk             (clk),
    .reset           (reset),
    .pop             (pop),
    .fifo_empty      (fifo_empty),
    .idle            (idle),
    .req             (req),
    .idx             (idx),
    .salida_contador (salida_contador),
    .valid_contador  (valid_contador)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int upd(input int v, input int d);
`ifdef COUNTER_SATURATE_EN
    return (v + d > 31) ? 31 : v + d;
`else
    return (v + d) % 32;
`endif
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 5; i++) m[i] = 0;
  endtask

  // One clock: drive, predict, advance model, then compare the registered read.
  task automatic cyc(input logic [3:0] p, input logic [3:0] e, input logic r,
                     input logic id, input logic [2:0] x, input string tag);
    logic [5:0] ex;
    logic [3:0] vp;
    @(negedge clk);
    pop = p; fifo_empty = e; req = r; idle = id; idx = x;
    ex = (r && id && x <= 3'd4) ? {1'b1, 5'(m[x])} : 6'd0;
    sbq.push_back(ex);
    vp = p & ~e;
    for (int i = 0; i < 4; i++) m[i] = upd(m[i], int'(vp[i]));
    m[4] = upd(m[4], $countones(vp));
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      chk({tag, "_sbq"}, 0, 1);
    end else begin
      ex = sbq.pop_front();
      chk({tag, "_v"}, int'(valid_contador), int'(ex[5]));
      chk({tag, "_d"}, int'(salida_contador), int'(ex[4:0]));
    end
  endtask

  task automatic rd_all(input string tag);
    for (int i = 0; i < 5; i++) cyc(4'h0, 4'h0, 1'b1, 1'b1, 3'(i), tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clr_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; pop = '0; fifo_empty = '0; idle = 1'b1; req = 1'b0; idx = '0;
    clr_model();
    #2;
    chk("rst0_v", int'(valid_contador), 0);
    chk("rst0_d", int'(salida_contador), 0);
    @(negedge clk); reset = 1'b1;
    rd_all("init");

    // Mixed pops, including one ignored on an empty FIFO.
    repeat (3) cyc(4'b0001, 4'h0, 1'b0, 1'b1, 3'd0, "p0");
    repeat (2) cyc(4'b0010, 4'h0, 1'b0, 1'b1, 3'd0, "p1");
    cyc(4'b1000, 4'h0, 1'b0, 1'b1, 3'd0, "p3");
    cyc(4'b0100, 4'b0100, 1'b0, 1'b1, 3'd0, "p2e");
    rd_all("mix");

    // Async reset while a read is being presented.
    cyc(4'h0, 4'h0, 1'b1, 1'b1, 3'd4, "pre");
    chk("pre_hi", int'(valid_contador), 1);
    reset = 1'b0;
    clr_model();
    #1;
    chk("arst_v", int'(valid_contador), 0);
    chk("arst_d", int'(salida_contador), 0);
    @(negedge clk); reset = 1'b1;
    rd_all("post");

    repeat (4) cyc(4'hF, 4'h0, 1'b0, 1'b1, 3'd0, "all");
    rd_all("sim");

    // Gating of reads.
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 3'd0, "nidle");
    cyc(4'h0, 4'h0, 1'b1, 1'b1, 3'd5, "idx5");
    cyc(4'h0, 4'h0, 1'b1, 1'b1, 3'd7, "idx7");
    cyc(4'h0, 4'h0, 1'b1, 1'b1, 3'd4, "idx4");
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 3'd4, "idrop");

    // Wrap / saturate on FIFO1.
    do_reset();
    repeat (33) cyc(4'b0010, 4'h0, 1'b0, 1'b1, 3'd0, "w");
    rd_all("wrap");

    // Same-edge pop and read of counter 2.
    do_reset();
    repeat (7) cyc(4'b0100, 4'h0, 1'b0, 1'b1, 3'd0, "c2");
    cyc(4'b0100, 4'h0, 1'b1, 1'b1, 3'd2, "same");
    cyc(4'h0, 4'h0, 1'b1, 1'b1, 3'd2, "after");

    // Random traffic including wraps/saturation and random gating.
    do_reset();
    for (int k = 0; k < 300; k++)
      cyc(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
          3'($urandom), "rnd");
    rd_all("end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/contador_palabras.md
# contador_palabras

Word-count block downstream of the four output (blue) FIFOs of the transaction layer. Counts every successful pop from each output FIFO in a 5-bit per-FIFO counter and keeps a fifth aggregate counter holding the total. Counters are read through a `req`/`idx` request port that is serviced only while the layer FSM reports `idle`; the result returns one cycle later on `salida_contador` with `valid_contador`.

## Interface
- `N_FIFOS`, 4, number of output FIFOs counted (fixed at 4; `idx` encoding depends on it)
- `CNT_W`, 5, counter width in bits
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately
- `pop`  in  4  pop strobes to output FIFOs 0..3
- `fifo_empty`  in  4  empty flags of output FIFOs 0..3, same cycle as `pop`
- `idle`  in  1  layer FSM is in IDLE; reads are serviced only when 1
- `req`  in  1  read request, sampled each rising edge
- `idx`  in  3  counter select: 0..3 per-FIFO, 4 aggregate, 5..7 invalid
- `salida_contador`  out  5  read data
- `valid_contador`  out  1  `salida_contador` holds a serviced read

## Operation
- Valid pop on FIFO i: `pop[i] & ~fifo_empty[i]`; pop on empty FIFO ignored.
- Per edge: `cnt[i] += 1` for each valid pop i; `cnt[4] += popcount(valid pops)` (0..4).
- Arithmetic modulo 2^CNT_W (wraps 31 -> 0) unless `COUNTER_SATURATE_EN`. Without the macro, `cnt[4] == (cnt0+cnt1+cnt2+cnt3) mod 32` holds every cycle.
- Read: at edge where `req & idle & idx<=4`, register `salida_contador <= cnt[idx]` (value before this edge's increments), `valid_contador <= 1`.
- Any other case (`req=0`, `idle=0`, `idx>=5`): `valid_contador <= 0`, `salida_contador <= 0`.
- No request queue: request dropped if not serviced; requester re-issues.
- Reads never modify counters; only reset clears them.

## Timing
- Reset (async assert): `cnt[0..4]=0`, `salida_contador=0`, `valid_contador=0`; deassert synchronous to `clk` by the driver.
- Count latency: valid pop at edge N visible to a read sampled at edge N+1.
- Read latency: 1 cycle; request sampled at edge N -> data/valid stable after edge N, until edge N+1.
- `req` held high with `idle=1`: back-to-back valid every cycle; `idx` may change each cycle.
- `idle` falls with `req` high: `valid_contador` drops after the next edge.
- Simultaneous pop and read of same counter: read returns pre-increment value.
- Reset mid-read: `valid_contador` drops asynchronously; no partial data.

## Configuration
- `COUNTER_SATURATE_EN` defined: every counter saturates at 31 (cnt[4] clamps at 31 when sum would exceed); sum invariant holds only until first saturation.
- Not defined: all counters wrap modulo 32.

## Structure
- Shared package `capa_pkg`: `N_FIFOS=4`, `CNT_W=5`, `IDX_SUM=3'd4`, `IDX_W=3`.
- Sub-module `contador_inc`: one CNT_W-bit register with 3-bit increment input (0..4), async active-low clear, wrap/saturate per macro; instantiated 5 times (per-FIFO with increment 0/1, aggregate with popcount).
- Top holds valid-pop mask, popcount, read mux and output registers.

## Test plan
- Reset: `reset=0` mid-run -> all counters 0, `valid_contador=0` immediately; read idx 0..4 after release -> 0 with valid.
- Pops: 3 pops FIFO0, 2 FIFO1, 1 FIFO3, one pop FIFO2 with `fifo_empty[2]=1` -> reads idx0..4 return 3,2,0,1,6.
- Simultaneous: `pop=4'hF`, no empties, 4 cycles -> idx0..3 each 4, idx4 = 16.
- Read gating: `req=1, idle=0, idx=0` -> `valid_contador=0`; `idx=5`, `idle=1` -> valid 0, data 0; `idle=1, idx=4` -> valid next cycle.
- Wrap: 33 valid pops on FIFO1 -> idx1 returns 1, idx4 returns 1 (macro off); with `COUNTER_SATURATE_EN` -> both 31.
- Same-edge pop+read on idx2 with cnt2=7 -> returns 7; next read returns 8.
